// File: rtl/break_value_selector.sv
// break_value_selector: serial greedy flip-candidate picker for the WSAT datapath.
// Popcounts one candidate break vector per clock, tracks the minimum eligible
// break value (lowest index wins ties) and pulses done with the result.
// Optional build macro: BVS_ZERO_EARLY_EXIT_EN -- stop scanning as soon as an
// eligible candidate breaks zero clauses.
module break_value_selector #(
  parameter int CLAUSE_W = 20,
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = $clog2(CLAUSE_W + 1),
  parameter int IDX_W    = $clog2(NUM_CAND)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_CAND*CLAUSE_W-1:0] brk_flat,
  input  logic [NUM_CAND-1:0]          cand_mask,
  output logic                         busy,
  output logic                         cnt_valid,
  output logic [IDX_W-1:0]             cnt_idx,
  output logic [CNT_W-1:0]             cnt_value,
  output logic                         done,
  output logic [IDX_W-1:0]             best_idx,
  output logic [CNT_W-1:0]             best_count,
  output logic                         none_valid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [NUM_CAND*CLAUSE_W-1:0] brk_q, brk_d;
  logic [NUM_CAND-1:0]          mask_q, mask_d;
  logic [IDX_W-1:0]             scan_idx_q, scan_idx_d;
  logic                         found_q, found_d;
  logic                         busy_q, busy_d;
  logic                         cnt_valid_q, cnt_valid_d;
  logic [IDX_W-1:0]             cnt_idx_q, cnt_idx_d;
  logic [CNT_W-1:0]             cnt_value_q, cnt_value_d;
  logic                         done_q, done_d;
  logic [IDX_W-1:0]             best_idx_q, best_idx_d;
  logic [CNT_W-1:0]             best_count_q, best_count_d;
  logic                         none_valid_q, none_valid_d;

  logic [CLAUSE_W-1:0]          cur_slice;
  logic [CNT_W-1:0]             cur_count;
  logic                         cur_elig;
  logic                         cur_better;
  logic                         last_cand;
  logic                         early_exit;

  // Popcount the latched vector of the candidate under the scan pointer.
  always_comb begin
    cur_slice = brk_q[int'(scan_idx_q)*CLAUSE_W +: CLAUSE_W];
    cur_count = '0;
    for (int b = 0; b < CLAUSE_W; b++) begin
      cur_count = cur_count + CNT_W'(cur_slice[b]);
    end
    cur_elig   = mask_q[scan_idx_q];
    cur_better = cur_elig && (!found_q || (cur_count < best_count_q));
    last_cand  = (scan_idx_q == IDX_W'(NUM_CAND - 1));
`ifdef BVS_ZERO_EARLY_EXIT_EN
    early_exit = cur_elig && (cur_count == '0);
`else
    early_exit = 1'b0;
`endif
  end

  // Next-state and next-output decode for the IDLE -> SCAN -> DONE sequence.
  always_comb begin
    state_d      = state_q;
    brk_d        = brk_q;
    mask_d       = mask_q;
    scan_idx_d   = scan_idx_q;
    found_d      = found_q;
    busy_d       = busy_q;
    cnt_valid_d  = 1'b0;
    cnt_idx_d    = cnt_idx_q;
    cnt_value_d  = cnt_value_q;
    done_d       = 1'b0;
    best_idx_d   = best_idx_q;
    best_count_d = best_count_q;
    none_valid_d = none_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_SCAN;
          brk_d        = brk_flat;
          mask_d       = cand_mask;
          scan_idx_d   = '0;
          found_d      = 1'b0;
          busy_d       = 1'b1;
          best_idx_d   = '0;
          best_count_d = '0;
          none_valid_d = 1'b0;
        end
      end

      ST_SCAN: begin
        if (cur_elig) begin
          cnt_valid_d = 1'b1;
          cnt_idx_d   = scan_idx_q;
          cnt_value_d = cur_count;
        end
        if (cur_better) begin
          best_idx_d   = scan_idx_q;
          best_count_d = cur_count;
          found_d      = 1'b1;
        end
        scan_idx_d = scan_idx_q + IDX_W'(1);
        if (last_cand || early_exit) begin
          state_d      = ST_DONE;
          done_d       = 1'b1;
          none_valid_d = !found_d;
          if (!found_d) begin
            best_idx_d   = '0;
            best_count_d = '0;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; low rst clears everything, mid-scan included.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      brk_q        <= '0;
      mask_q       <= '0;
      scan_idx_q   <= '0;
      found_q      <= 1'b0;
      busy_q       <= 1'b0;
      cnt_valid_q  <= 1'b0;
      cnt_idx_q    <= '0;
      cnt_value_q  <= '0;
      done_q       <= 1'b0;
      best_idx_q   <= '0;
      best_count_q <= '0;
      none_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      brk_q        <= brk_d;
      mask_q       <= mask_d;
      scan_idx_q   <= scan_idx_d;
      found_q      <= found_d;
      busy_q       <= busy_d;
      cnt_valid_q  <= cnt_valid_d;
      cnt_idx_q    <= cnt_idx_d;
      cnt_value_q  <= cnt_value_d;
      done_q       <= done_d;
      best_idx_q   <= best_idx_d;
      best_count_q <= best_count_d;
      none_valid_q <= none_valid_d;
    end
  end

  assign busy       = busy_q;
  assign cnt_valid  = cnt_valid_q;
  assign cnt_idx    = cnt_idx_q;
  assign cnt_value  = cnt_value_q;
  assign done       = done_q;
  assign best_idx   = best_idx_q;
  assign best_count = best_count_q;
  assign none_valid = none_valid_q;

endmodule

// File: tb/tb_break_value_selector.sv
// tb_break_value_selector: table-driven, directed and randomized checks of
// break_value_selector against a popcount reference model.
module tb_break_value_selector;

  localparam int CLAUSE_W = 20;
  localparam int NUM_CAND = 4;
  localparam int CNT_W    = $clog2(CLAUSE_W + 1);
  localparam int IDX_W    = $clog2(NUM_CAND);
  localparam int FLAT_W   = NUM_CAND * CLAUSE_W;
`ifdef BVS_ZERO_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [FLAT_W-1:0]   brk_flat;
  logic [NUM_CAND-1:0] cand_mask;
  logic                busy;
  logic                cnt_valid;
  logic [IDX_W-1:0]    cnt_idx;
  logic [CNT_W-1:0]    cnt_value;
  logic                done;
  logic [IDX_W-1:0]    best_idx;
  logic [CNT_W-1:0]    best_count;
  logic                none_valid;

  break_value_selector #(
    .CLAUSE_W(CLAUSE_W),
    .NUM_CAND(NUM_CAND)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .brk_flat  (brk_flat),
    .cand_mask (cand_mask),
    .busy      (busy),
    .cnt_valid (cnt_valid),
    .cnt_idx   (cnt_idx),
    .cnt_value (cnt_value),
    .done      (done),
    .best_idx  (best_idx),
    .best_count(best_count),
    .none_valid(none_valid)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference-model expectations for the current request.
  int exp_lat, exp_best_idx, exp_best_count, exp_none, exp_n_ev;
  int exp_ev_idx[NUM_CAND];
  int exp_ev_cnt[NUM_CAND];

  // Values observed on the DUT for the most recent request.
  int got_lat_r, got_bidx_r, got_bcnt_r, got_none_r;

  typedef struct {
    logic [FLAT_W-1:0]   brk;
    logic [NUM_CAND-1:0] mask;
    int                  lat;
    int                  bidx;
    int                  bcnt;
    int                  none;
  } vec_t;

  vec_t vecs[7];

  // Single comparison point for every check.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Greedy selection straight from the rules: popcount each eligible vector,
  // keep the strictly smaller one, optionally stop on the first zero.
  task automatic ref_model(input logic [FLAT_W-1:0] brk, input logic [NUM_CAND-1:0] mask);
    bit found;
    int c;
    found          = 1'b0;
    exp_best_idx   = 0;
    exp_best_count = 0;
    exp_n_ev       = 0;
    exp_lat        = NUM_CAND;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (mask[i]) begin
        c = $countones(brk[i*CLAUSE_W +: CLAUSE_W]);
        exp_ev_idx[exp_n_ev] = i;
        exp_ev_cnt[exp_n_ev] = c;
        exp_n_ev++;
        if (!found || c < exp_best_count) begin
          exp_best_idx   = i;
          exp_best_count = c;
          found          = 1'b1;
        end
        if (EARLY && c == 0) begin
          exp_lat = i + 1;
          break;
        end
      end
    end
    exp_none = found ? 0 : 1;
  endtask

  // Run one selection, optionally pulsing start while busy, and compare the
  // strobe stream, latency and result against the model.
  task automatic applyStimulus(input string name, input logic [FLAT_W-1:0] brk,
                               input logic [NUM_CAND-1:0] mask, input bit restart);
    int got_lat;
    int n_got;
    int got_idx[NUM_CAND];
    int got_cnt[NUM_CAND];
    ref_model(brk, mask);
    @(negedge clk);
    brk_flat  = brk;
    cand_mask = mask;
    start     = 1'b1;
    @(posedge clk);
    #1;
    checkOutput($sformatf("%s busy_after_start", name), int'(busy), 1);
    brk_flat  = {$urandom, $urandom, $urandom};
    cand_mask = NUM_CAND'($urandom);
    if (!restart) start = 1'b0;
    got_lat = -1;
    n_got   = 0;
    for (int k = 1; k <= NUM_CAND + 2; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) start = 1'b0;
      if (cnt_valid) begin
        if (n_got < NUM_CAND) begin
          got_idx[n_got] = int'(cnt_idx);
          got_cnt[n_got] = int'(cnt_value);
        end
        n_got++;
      end
      if (done) begin
        got_lat = k;
        break;
      end
    end
    checkOutput($sformatf("%s latency", name), got_lat, exp_lat);
    checkOutput($sformatf("%s strobe_count", name), n_got, exp_n_ev);
    for (int j = 0; j < exp_n_ev && j < n_got; j++) begin
      checkOutput($sformatf("%s cnt_idx[%0d]", name, j), got_idx[j], exp_ev_idx[j]);
      checkOutput($sformatf("%s cnt_value[%0d]", name, j), got_cnt[j], exp_ev_cnt[j]);
    end
    got_lat_r  = got_lat;
    got_bidx_r = int'(best_idx);
    got_bcnt_r = int'(best_count);
    got_none_r = int'(none_valid);
    checkOutput($sformatf("%s best_idx", name), got_bidx_r, exp_best_idx);
    checkOutput($sformatf("%s best_count", name), got_bcnt_r, exp_best_count);
    checkOutput($sformatf("%s none_valid", name), got_none_r, exp_none);
    checkOutput($sformatf("%s busy_at_done", name), int'(busy), 1);
    if (restart) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput($sformatf("%s done_one_cycle", name), int'(done), 0);
    checkOutput($sformatf("%s busy_after_done", name), int'(busy), 0);
    checkOutput($sformatf("%s cnt_valid_after_done", name), int'(cnt_valid), 0);
    checkOutput($sformatf("%s best_idx_hold", name), int'(best_idx), exp_best_idx);
    checkOutput($sformatf("%s best_count_hold", name), int'(best_count), exp_best_count);
  endtask

  // Every output must read zero while or just after reset is applied.
  task automatic checkAllZero(input string name);
    checkOutput($sformatf("%s busy", name), int'(busy), 0);
    checkOutput($sformatf("%s done", name), int'(done), 0);
    checkOutput($sformatf("%s cnt_valid", name), int'(cnt_valid), 0);
    checkOutput($sformatf("%s best_idx", name), int'(best_idx), 0);
    checkOutput($sformatf("%s best_count", name), int'(best_count), 0);
    checkOutput($sformatf("%s none_valid", name), int'(none_valid), 0);
  endtask

  function automatic logic [FLAT_W-1:0] pack4(input logic [CLAUSE_W-1:0] c0, input logic [CLAUSE_W-1:0] c1,
                                              input logic [CLAUSE_W-1:0] c2, input logic [CLAUSE_W-1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // Main sequence: reset, table vectors, busy/restart, mid-scan reset, random.
  initial begin
    logic [FLAT_W-1:0]   rbrk;
    logic [NUM_CAND-1:0] rmask;
    logic [CLAUSE_W-1:0] v;
    bit                  saw_done;

    vecs[0] = '{pack4(20'b10, 20'b111, 20'b1111, 20'h05556), 4'b1111, 4, 0, 1, 0};
    vecs[1] = '{pack4(20'h7, 20'h1, 20'h80000, 20'h1F), 4'b1111, 4, 1, 1, 0};
    vecs[2] = '{pack4(20'h0, 20'hF, 20'h1FF, 20'h3), 4'b1010, 4, 3, 2, 0};
    vecs[3] = '{pack4(20'b10, 20'b111, 20'b1111, 20'h05556), 4'b0000, 4, 0, 0, 1};
    vecs[4] = '{pack4(20'h1F, 20'h3, 20'h0, 20'h1), 4'b1111, (EARLY ? 3 : 4), 2, 0, 0};
    vecs[5] = '{pack4(20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF), 4'b1111, 4, 0, 20, 0};
    vecs[6] = '{pack4(20'h0, 20'h0, 20'h0, 20'hFFFFF), 4'b1000, 4, 3, 20, 0};

    rst       = 1'b0;
    start     = 1'b1;
    brk_flat  = {$urandom, $urandom, $urandom};
    cand_mask = '1;

    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #1;
      checkAllZero($sformatf("reset%0d", r));
    end
    start = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release busy", int'(busy), 0);

    for (int t = 0; t < 7; t++) begin
      applyStimulus($sformatf("vec%0d", t), vecs[t].brk, vecs[t].mask, 1'b0);
      checkOutput($sformatf("vec%0d table_latency", t), got_lat_r, vecs[t].lat);
      checkOutput($sformatf("vec%0d table_best_idx", t), got_bidx_r, vecs[t].bidx);
      checkOutput($sformatf("vec%0d table_best_count", t), got_bcnt_r, vecs[t].bcnt);
      checkOutput($sformatf("vec%0d table_none_valid", t), got_none_r, vecs[t].none);
    end

    applyStimulus("restart_ignored", vecs[1].brk, vecs[1].mask, 1'b1);
    checkOutput("restart_ignored table_best_idx", got_bidx_r, 1);
    checkOutput("restart_ignored table_best_count", got_bcnt_r, 1);

    @(negedge clk);
    brk_flat  = vecs[0].brk;
    cand_mask = 4'b1111;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkAllZero("midscan_reset");
    @(negedge clk);
    rst      = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < NUM_CAND + 2; k++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    checkOutput("midscan_reset no_done", int'(saw_done), 0);
    checkOutput("midscan_reset idle", int'(busy), 0);
    applyStimulus("after_reset", vecs[1].brk, vecs[1].mask, 1'b0);

    for (int t = 0; t < 40; t++) begin
      rbrk = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
        case ($urandom_range(0, 3))
          0:       v = '0;
          1:       v = '1;
          2:       v = CLAUSE_W'($urandom);
          default: v = CLAUSE_W'(1) << $urandom_range(0, CLAUSE_W - 1);
        endcase
        rbrk[i*CLAUSE_W +: CLAUSE_W] = v;
      end
      rmask = NUM_CAND'($urandom);
      applyStimulus($sformatf("rand%0d", t), rbrk, rmask, (t % 5) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
